load_store_unit: RTL and testbench

- Memory stage directly downstream of the ALU in the RISC-V 32I core.
- Takes the ALU result as the effective address, plus funct3, store data and rd, for one load or store.
- Drives a word-aligned valid/ready data-memory port, handles byte lanes and sign/zero extension, and returns load data to writeback.
- Flags misaligned or illegal accesses instead of issuing them; one access in flight at a time.

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load or store in flight. It checks legality, drives a word-aligned
// valid/ready data port, and returns sign/zero-extended load data to writeback.
module load_store_unit #(
    parameter int unsigned REG_SIZE  = 32,
    parameter int unsigned REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [REG_SIZE-1:0]  req_addr,
    input  logic [REG_SIZE-1:0]  req_wdata,
    input  logic [REG_WIDTH-1:0] req_rd,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [REG_SIZE-1:0]  mem_addr,
    output logic [REG_SIZE-1:0]  mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_rvalid,
    input  logic [REG_SIZE-1:0]  mem_rdata,
    output logic                 wb_valid,
    output logic [REG_WIDTH-1:0] wb_rd,
    output logic [REG_SIZE-1:0]  wb_data,
    output logic                 st_done,
    output logic                 exc_valid,
    output logic [REG_SIZE-1:0]  exc_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t               state_q, state_d;
    logic                 req_ready_q, req_ready_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 mem_we_q, mem_we_d;
    logic [REG_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic [REG_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
    logic [3:0]           mem_wstrb_q, mem_wstrb_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic [REG_WIDTH-1:0] rd_q, rd_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [REG_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [REG_SIZE-1:0]  wb_data_q, wb_data_d;
    logic                 st_done_q, st_done_d;
    logic                 exc_valid_q, exc_valid_d;
    logic [REG_SIZE-1:0]  exc_addr_q, exc_addr_d;

    logic                 accept;
    logic                 funct3_bad;
    logic                 misaligned;
    logic                 acc_fault;
    logic [REG_SIZE-1:0]  rdata_sh;
    logic [REG_SIZE-1:0]  load_ext;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            st_done_q   <= 1'b0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            st_done_q   <= st_done_d;
            exc_valid_q <= exc_valid_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    // Legality of the presented access, evaluated only at accept
    always_comb begin
        accept     = req_valid && req_ready_q;
        funct3_bad = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        acc_fault  = funct3_bad || misaligned;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !acc_fault) state_d = REQ;
            REQ:     if (mem_ready) state_d = mem_we_q ? IDLE : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load lane select and extension
    always_comb begin
        rdata_sh = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = REG_SIZE'({{24{rdata_sh[7]}}, rdata_sh[7:0]});
            3'b001:  load_ext = REG_SIZE'({{16{rdata_sh[15]}}, rdata_sh[15:0]});
            3'b100:  load_ext = REG_SIZE'({24'd0, rdata_sh[7:0]});
            3'b101:  load_ext = REG_SIZE'({16'd0, rdata_sh[15:0]});
            default: load_ext = rdata_sh;
        endcase
    end

    // Output / datapath next values; mem_* and writeback fields hold unless updated
    always_comb begin
        req_ready_d = (state_d == IDLE);
        mem_valid_d = (state_d == REQ);
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        st_done_d   = 1'b0;
        exc_valid_d = 1'b0;
        exc_addr_d  = exc_addr_q;

        if (accept && acc_fault) begin
            exc_valid_d = 1'b1;
            exc_addr_d  = req_addr;
        end else if (accept) begin
            mem_we_d   = req_we;
            mem_addr_d = {req_addr[REG_SIZE-1:2], 2'b00};
            funct3_d   = req_funct3;
            off_d      = req_addr[1:0];
            rd_d       = req_rd;
            if (!req_we) begin
                mem_wdata_d = '0;
                mem_wstrb_d = 4'b0000;
            end else begin
                case (req_funct3[1:0])
                    2'b00: begin
                        mem_wdata_d = REG_SIZE'({4{req_wdata[7:0]}});
                        mem_wstrb_d = 4'b0001 << req_addr[1:0];
                    end
                    2'b01: begin
                        mem_wdata_d = REG_SIZE'({2{req_wdata[15:0]}});
                        mem_wstrb_d = req_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        mem_wdata_d = req_wdata;
                        mem_wstrb_d = 4'b1111;
                    end
                endcase
            end
        end

        if ((state_q == REQ) && mem_ready && mem_we_q) st_done_d = 1'b1;

        if ((state_q == WAIT_R) && mem_rvalid) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_ext;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign st_done   = st_done_q;
    assign exc_valid = exc_valid_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, load extension, faults, stalls, reset and back-to-back.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        exc_valid;
    logic [31:0] exc_addr;

    int n_run  = 0;
    int n_fail = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .st_done(st_done),
        .exc_valid(exc_valid), .exc_addr(exc_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
    endtask

    // Zero-wait load: accept, one REQ cycle, rvalid right after; leaves bench in the wb_valid cycle
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] rdata);
        drive_req(1'b0, f3, addr, 32'h0, rd);
        mem_ready = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        tick(); mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        tick(); tick();
        n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
        n_run++; if ({mem_valid, mem_we, wb_valid, st_done, exc_valid} !== 5'b0) begin
            n_fail++; $display("FAIL rst_flags got=%b want=00000", {mem_valid, mem_we, wb_valid, st_done, exc_valid}); end
        n_run++; if ({mem_addr, mem_wdata, wb_data, exc_addr} !== 128'h0) begin
            n_fail++; $display("FAIL rst_data got=%h want=0", {mem_addr, mem_wdata, wb_data, exc_addr}); end
        n_run++; if ({mem_wstrb, wb_rd} !== 9'h0) begin n_fail++; $display("FAIL rst_strb_rd got=%h want=0", {mem_wstrb, wb_rd}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_store();
        drive_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
        mem_ready = 1'b1;
        tick(); req_valid = 1'b0;
        n_run++; if (mem_valid !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_valid_we got=%b%b want=11", mem_valid, mem_we); end
        n_run++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got=%h want=00000100", mem_addr); end
        n_run++; if (mem_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb got=%b want=1111", mem_wstrb); end
        n_run++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got=%h want=deadbeef", mem_wdata); end
        n_run++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_busy got=%b want=0", req_ready); end
        tick();
        n_run++; if (st_done !== 1'b1 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL sw_done got=%b valid=%b want=1 0", st_done, mem_valid); end
        mem_ready = 1'b0;
        tick();
        n_run++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL sw_done_pulse got=%b want=0", st_done); end

        drive_req(1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd0);
        tick(); req_valid = 1'b0;
        n_run++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL sb_addr got=%h want=00000200", mem_addr); end
        n_run++; if (mem_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb got=%b want=1000", mem_wstrb); end
        n_run++; if (mem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", mem_wdata); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        n_run++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL sb_done got=%b want=1", st_done); end
        tick();

        drive_req(1'b1, 3'b001, 32'h006, 32'hFFFF1234, 5'd0);
        tick(); req_valid = 1'b0;
        n_run++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'h12341234) begin
            n_fail++; $display("FAIL sh_lane got=%b %h want=1100 12341234", mem_wstrb, mem_wdata); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_load_ext();
        run_load(3'b000, 32'h302, 5'd5, 32'h1280FF34);
        n_run++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5) begin n_fail++; $display("FAIL lb_wb got=%b rd=%0d want=1 rd=5", wb_valid, wb_rd); end
        n_run++; if (wb_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data got=%h want=ffffff80", wb_data); end
        tick();
        n_run++; if (wb_valid !== 1'b0 || wb_data !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_hold got=%b %h want=0 ffffff80", wb_valid, wb_data); end
        run_load(3'b100, 32'h302, 5'd6, 32'h1280FF34);
        n_run++; if (wb_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data got=%h want=00000080", wb_data); end
        tick();
        run_load(3'b001, 32'h302, 5'd7, 32'h1280FF34);
        n_run++; if (wb_data !== 32'h00001280) begin n_fail++; $display("FAIL lh_data got=%h want=00001280", wb_data); end
        tick();
        run_load(3'b001, 32'h300, 5'd8, 32'h1280FF34);
        n_run++; if (wb_data !== 32'hFFFFFF34) begin n_fail++; $display("FAIL lh_lo_data got=%h want=ffffff34", wb_data); end
        tick();
        run_load(3'b101, 32'h300, 5'd9, 32'h1280FF34);
        n_run++; if (wb_data !== 32'h0000FF34) begin n_fail++; $display("FAIL lhu_data got=%h want=0000ff34", wb_data); end
        tick();
        run_load(3'b010, 32'h300, 5'd0, 32'h1280FF34);
        n_run++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'h1280FF34) begin
            n_fail++; $display("FAIL lw_rd0 got=%b rd=%0d %h want=1 rd=0 1280ff34", wb_valid, wb_rd, wb_data); end
        tick();
    endtask

    task automatic test_exceptions();
        drive_req(1'b0, 3'b010, 32'h401, 32'h0, 5'd3);
        tick(); req_valid = 1'b0;
        n_run++; if (exc_valid !== 1'b1 || exc_addr !== 32'h401) begin
            n_fail++; $display("FAIL lw_mis_exc got=%b %h want=1 00000401", exc_valid, exc_addr); end
        n_run++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL lw_mis_nomem got=valid %b ready %b want=0 1", mem_valid, req_ready); end
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        tick(); mem_rvalid = 1'b0;
        n_run++; if (exc_valid !== 1'b0 || mem_valid !== 1'b0 || exc_addr !== 32'h401) begin
            n_fail++; $display("FAIL lw_mis_after got=%b %b %h want=0 0 00000401", exc_valid, mem_valid, exc_addr); end
        tick();
        n_run++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid got=%b want=0", wb_valid); end

        drive_req(1'b1, 3'b011, 32'h500, 32'h12345678, 5'd0);
        tick(); req_valid = 1'b0;
        n_run++; if (exc_valid !== 1'b1 || exc_addr !== 32'h500 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL st_f3_exc got=%b %h %b want=1 00000500 0", exc_valid, exc_addr, mem_valid); end
        tick();

        drive_req(1'b0, 3'b110, 32'h600, 32'h0, 5'd1);
        tick(); req_valid = 1'b0;
        n_run++; if (exc_valid !== 1'b1 || exc_addr !== 32'h600 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL ld_f3_exc got=%b %h %b want=1 00000600 0", exc_valid, exc_addr, mem_valid); end
        tick();

        drive_req(1'b1, 3'b001, 32'h703, 32'h0, 5'd0);
        tick(); req_valid = 1'b0;
        n_run++; if (exc_valid !== 1'b1 || exc_addr !== 32'h703 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL sh_mis_exc got=%b %h %b want=1 00000703 0", exc_valid, exc_addr, mem_valid); end
        tick();
    endtask

    task automatic test_stall();
        drive_req(1'b0, 3'b010, 32'h800, 32'h0, 5'd7);
        mem_ready = 1'b0;
        tick(); req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_run++; if (mem_valid !== 1'b1 || mem_addr !== 32'h800 || mem_wstrb !== 4'b0000 || mem_we !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d] got=%b %h %b %b %b want=1 00000800 0000 0 0",
                                    i, mem_valid, mem_addr, mem_wstrb, mem_we, req_ready); end
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        n_run++; if (mem_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_waitr got=%b %b want=0 0", mem_valid, req_ready); end
        tick();
        n_run++; if (req_ready !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_rwait got=%b %b want=0 0", req_ready, wb_valid); end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick(); mem_rvalid = 1'b0;
        n_run++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hCAFEF00D || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_wb got=%b %0d %h %b want=1 7 cafef00d 1", wb_valid, wb_rd, wb_data, req_ready); end
        tick();
        n_run++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single got=%b want=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 3'b010, 32'h900, 32'h11223344, 5'd0);
        mem_ready = 1'b1;
        tick(); req_valid = 1'b0;
        tick();
        drive_req(1'b0, 3'b100, 32'h901, 32'h0, 5'd3);
        n_run++; if (st_done !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done got=%b %b want=1 1", st_done, req_ready); end
        tick(); req_valid = 1'b0;
        n_run++; if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h900 || st_done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept got=%b %b %h %b want=1 0 00000900 0", mem_valid, mem_we, mem_addr, st_done); end
        tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000AB00;
        tick(); mem_rvalid = 1'b0;
        n_run++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h000000AB) begin
            n_fail++; $display("FAIL b2b_load got=%b %0d %h want=1 3 000000ab", wb_valid, wb_rd, wb_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 3'b010, 32'hA00, 32'h0, 5'd9);
        mem_ready = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_run++; if (req_ready !== 1'b1 || mem_valid !== 1'b0 || mem_addr !== 32'h0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_out got=%b %b %h %b %0d %h want=1 0 0 0 0 0",
                                req_ready, mem_valid, mem_addr, wb_valid, wb_rd, wb_data); end
        tick(); reset = 1'b0;
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick(); mem_rvalid = 1'b0;
        n_run++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_rvalid got=%b %b want=0 1", wb_valid, req_ready); end
        tick();
        n_run++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_nowb got=%b %h want=0 0", wb_valid, wb_data); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store();
        test_load_ext();
        test_exceptions();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
